wb_fifo_slave: RTL and testbench

- Wishbone B4 classic responder sitting on a bus-matrix slave port, alongside the RAM slaves.
- A master (DAQ or DSP) streams 32-bit samples into an internal FIFO by writing its DATA register.
- Another master drains the FIFO by reading DATA.
- Control, status and threshold registers plus a level interrupt let the DSP side poll or be notified without touching RAM.

---
 rtl/wb_fifo_slave_pkg.sv | 29 ++
 rtl/wb_fifo_slave_if.sv | 32 +++
 rtl/wb_fifo_slave_sync_fifo.sv | 60 ++++++
 rtl/wb_fifo_slave.sv | 169 ++++++++++++++++
 tb/tb_wb_fifo_slave.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_fifo_slave_pkg.sv
// Register map, bit positions and bus FSM states shared by the FIFO slave.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_fifo_slave_pkg;

    // Register offsets decoded from wb_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    // STATUS bit indices (level occupies the low bits)
    localparam int STAT_EMPTY = 16;
    localparam int STAT_FULL  = 17;
    localparam int STAT_OVF   = 18;
    localparam int STAT_UDF   = 19;

    // Bus handshake FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/wb_fifo_slave_if.sv
// Wishbone B4 classic bus bundle between a bus-matrix port and the FIFO slave.
// Latency: none (wires only).
// Backpressure: carried by ack/err/rty back to the master.
interface wb_fifo_slave_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0] wb_adr_i;
    logic [dw-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [dw-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
               wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
               wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_fifo_slave_sync_fifo.sv
// Single-clock FIFO with synchronous clear; dout shows the head word combinationally.
// Latency: a push is visible at dout/level on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; caller checks flags.
module sync_fifo #(
    parameter int dw         = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clr_i,
    input  logic [dw-1:0]         din_i,
    output logic [dw-1:0]         dout_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [dw-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Pointer next-state; clear wins over any access in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && !full_o) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !clr_i) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din_i;
    end
endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone classic slave exposing CTRL/STATUS/DATA/THRESH over an internal sample FIFO.
// Latency: request sampled at edge N, ack or err high for the single cycle N+1.
// Backpressure: none stalls; full push / empty pop terminate with err instead.
module wb_fifo_slave
    import wb_fifo_slave_pkg::*;
#(
    parameter int dw         = 32,
    parameter int aw         = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    wb_fifo_slave_if.slave    bus,
    output logic              irq_o
);
    localparam int LW = DEPTH_LOG2 + 1;

    state_t          state_q, state_d;
    logic            ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic            en_q, en_d, irq_en_q, irq_en_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic [LW-1:0]   thresh_q, thresh_d;
    logic            push, pop, clr;
    logic [dw-1:0]   fifo_dout;
    logic [LW-1:0]   level;
    logic            empty, full;
    logic [1:0]      reg_sel;
    logic            unused_ok;

    assign reg_sel   = bus.wb_adr_i[3:2];
    // Burst hints are accepted but every access is handled as classic
    assign unused_ok = ^{bus.wb_cti_i, bus.wb_bte_i, bus.wb_adr_i[aw-1:4], bus.wb_adr_i[1:0]};

    assign bus.wb_dat_o = dat_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_rty_o = 1'b0;
    assign irq_o        = irq_q;

    sync_fifo #(.dw(dw), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk_i   (wb_clk),
        .rst_n_i (wb_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (clr),
        .din_i   (bus.wb_dat_i),
        .dout_o  (fifo_dout),
        .level_o (level),
        .empty_o (empty),
        .full_o  (full)
    );

    // Access decode, register updates and response selection for the bus FSM
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        thresh_d = thresh_q;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = '0;
                    case (reg_sel)
                        REG_CTRL: begin
                            if (bus.wb_we_i) begin
                                if (bus.wb_sel_i[0]) begin
                                    en_d     = bus.wb_dat_i[CTRL_EN];
                                    irq_en_d = bus.wb_dat_i[CTRL_IRQ_EN];
                                    clr      = bus.wb_dat_i[CTRL_CLR];
                                end
                            end else begin
                                dat_d[CTRL_EN]     = en_q;
                                dat_d[CTRL_IRQ_EN] = irq_en_q;
                            end
                        end
                        REG_STATUS: begin
                            if (bus.wb_we_i) begin
                                if (bus.wb_sel_i[2]) begin
                                    if (bus.wb_dat_i[STAT_OVF]) ovf_d = 1'b0;
                                    if (bus.wb_dat_i[STAT_UDF]) udf_d = 1'b0;
                                end
                            end else begin
                                dat_d[LW-1:0]     = level;
                                dat_d[STAT_EMPTY] = empty;
                                dat_d[STAT_FULL]  = full;
                                dat_d[STAT_OVF]   = ovf_q;
                                dat_d[STAT_UDF]   = udf_q;
                            end
                        end
                        REG_DATA: begin
                            if (bus.wb_we_i) begin
                                // Partial-word pushes are refused outright
                                if (bus.wb_sel_i != 4'hF) begin
                                    ack_d = 1'b0;
                                    err_d = 1'b1;
                                end else if (!en_q) begin
                                    // Disabled: discard silently so producers never stall
                                end else if (full) begin
                                    ack_d = 1'b0;
                                    err_d = 1'b1;
                                    ovf_d = 1'b1;
                                end else begin
                                    push = 1'b1;
                                end
                            end else if (empty) begin
                                ack_d = 1'b0;
                                err_d = 1'b1;
                                udf_d = 1'b1;
                            end else begin
                                dat_d = fifo_dout;
                                pop   = 1'b1;
                            end
                        end
                        REG_THRESH: begin
                            if (bus.wb_we_i) begin
                                if (bus.wb_sel_i[0]) thresh_d = bus.wb_dat_i[LW-1:0];
                            end else begin
                                dat_d[LW-1:0] = thresh_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Threshold of zero disables the interrupt rather than holding it high
        irq_d = irq_en_q && en_q && (level >= thresh_q) && (thresh_q != '0);
    end

    // State, response and register storage
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            thresh_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            thresh_q <= thresh_d;
        end
    end
endmodule

// File: tb/tb_wb_fifo_slave.sv
// Scoreboard bench for wb_fifo_slave: queue-based reference model, directed plan then random traffic.
// Latency: expects ack/err in the cycle after the sampling edge.
// Backpressure: accesses issued one at a time, two cycles apart.
module tb_wb_fifo_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    wb_fifo_slave_if #(.dw(32), .aw(32)) bus ();

    wb_fifo_slave #(.dw(32), .aw(32), .DEPTH_LOG2(4)) dut (
        .wb_clk   (clk),
        .wb_rst_n (rst_n),
        .bus      (bus),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ack;
        bit          err;
        logic [31:0] dat;
    } resp_t;

    resp_t       exp_q[$];
    int unsigned mq[$];
    bit          m_en, m_irqen, m_ovf, m_udf;
    int          m_th;
    bit          irq_pipe;
    logic [31:0] last_dat;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s     = 32'(mq.size());
        s[16] = (mq.size() == 0);
        s[17] = (mq.size() == 16);
        s[18] = m_ovf;
        s[19] = m_udf;
        return s;
    endfunction

    function automatic bit m_irq();
        return m_irqen && m_en && (m_th != 0) && (int'(mq.size()) >= m_th);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, expv);
        end
    endtask

    // One bus access; the model is updated after the sampling edge
    task automatic access(input logic [1:0] r, input bit we, input logic [31:0] wd,
                          input logic [3:0] sel);
        resp_t e;
        @(negedge clk);
        bus.wb_adr_i = {28'h0, r, 2'b00};
        bus.wb_we_i  = we;
        bus.wb_dat_i = wd;
        bus.wb_sel_i = sel;
        bus.wb_cti_i = 3'($urandom);
        bus.wb_bte_i = 2'($urandom);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        e.ack = 1'b1;
        e.err = 1'b0;
        e.dat = 32'h0;
        case (r)
            2'd0: begin
                if (we) begin
                    if (sel[0]) begin
                        m_en    = wd[0];
                        m_irqen = wd[1];
                        if (wd[2]) mq.delete();
                    end
                end else begin
                    e.dat = {30'h0, m_irqen, m_en};
                end
            end
            2'd1: begin
                if (we) begin
                    if (sel[2] && wd[18]) m_ovf = 1'b0;
                    if (sel[2] && wd[19]) m_udf = 1'b0;
                end else begin
                    e.dat = m_status();
                end
            end
            2'd2: begin
                if (we) begin
                    if (sel != 4'hF) begin
                        e.ack = 1'b0; e.err = 1'b1;
                    end else if (m_en) begin
                        if (mq.size() == 16) begin
                            e.ack = 1'b0; e.err = 1'b1; m_ovf = 1'b1;
                        end else begin
                            mq.push_back(wd);
                        end
                    end
                end else if (mq.size() == 0) begin
                    e.ack = 1'b0; e.err = 1'b1; m_udf = 1'b1;
                end else begin
                    e.dat = mq.pop_front();
                end
            end
            default: begin
                if (we) begin
                    if (sel[0]) m_th = int'(wd[4:0]);
                end else begin
                    e.dat = 32'(m_th);
                end
            end
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL no_response pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every termination and tracks irq one cycle behind the model
    always @(negedge clk) begin
        resp_t e;
        if (!rst_n) begin
            irq_pipe = 1'b0;
        end else begin
            if (bus.wb_ack_o || bus.wb_err_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp ack=%b err=%b want=none", bus.wb_ack_o, bus.wb_err_o);
                end else begin
                    e = exp_q.pop_front();
                    last_dat = bus.wb_dat_o;
                    if (bus.wb_ack_o !== e.ack || bus.wb_err_o !== e.err || bus.wb_dat_o !== e.dat) begin
                        errors++;
                        $display("FAIL resp got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                                 bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, e.ack, e.err, e.dat);
                    end
                end
            end
            checks++;
            if (irq !== irq_pipe) begin
                errors++;
                $display("FAIL irq got=%b want=%b level=%0d th=%0d", irq, irq_pipe, mq.size(), m_th);
            end
            irq_pipe = m_irq();
        end
    end

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_en = 0; m_irqen = 0; m_ovf = 0; m_udf = 0; m_th = 0;
    endtask

    initial begin
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;
        model_reset();
        #3;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        chk("rst_err", 32'(bus.wb_err_o), 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        #9 rst_n = 1'b1;

        access(2'd1, 0, 0, 4'hF);
        chk("status_reset", last_dat, 32'h0001_0000);

        // Basic order
        access(2'd0, 1, 32'h1, 4'hF);
        for (int i = 1; i <= 3; i++) access(2'd2, 1, 32'hDEAD_0000 + 32'(i), 4'hF);
        for (int i = 1; i <= 3; i++) begin
            access(2'd2, 0, 0, 4'hF);
            chk("pop_order", last_dat, 32'hDEAD_0000 + 32'(i));
        end
        access(2'd1, 0, 0, 4'hF);
        chk("status_drained", last_dat, 32'h0001_0000);

        // Full and overflow
        for (int i = 0; i < 16; i++) access(2'd2, 1, 32'h1000 + 32'(i), 4'hF);
        access(2'd1, 0, 0, 4'hF);
        chk("status_full", last_dat, 32'h0002_0010);
        access(2'd2, 1, 32'hBAD0_0000, 4'hF);
        access(2'd1, 0, 0, 4'hF);
        chk("status_ovf", last_dat, 32'h0006_0010);
        access(2'd1, 1, 32'h0004_0000, 4'hF);
        access(2'd1, 0, 0, 4'hF);
        chk("status_ovf_clr", last_dat, 32'h0002_0010);
        access(2'd2, 1, 32'h5, 4'h7);
        for (int i = 0; i < 16; i++) access(2'd2, 0, 0, 4'hF);

        // Underflow and disabled discard
        access(2'd2, 0, 0, 4'hF);
        access(2'd0, 1, 32'h0, 4'hF);
        access(2'd2, 1, 32'h1234_5678, 4'hF);
        access(2'd1, 0, 0, 4'hF);
        chk("status_udf_disabled", last_dat, 32'h0009_0000);
        access(2'd1, 1, 32'h0008_0000, 4'hF);

        // Interrupt threshold
        access(2'd3, 1, 32'h4, 4'hF);
        access(2'd0, 1, 32'h3, 4'hF);
        for (int i = 0; i < 3; i++) access(2'd2, 1, 32'hA0 + 32'(i), 4'hF);
        repeat (2) @(negedge clk);
        #1 chk("irq_below", 32'(irq), 32'h0);
        access(2'd2, 1, 32'hA3, 4'hF);
        @(negedge clk);
        #1 chk("irq_at_thresh", 32'(irq), 32'h1);
        access(2'd2, 0, 0, 4'hF);
        @(negedge clk);
        #1 chk("irq_after_pop", 32'(irq), 32'h0);
        access(2'd3, 0, 0, 4'hF);
        chk("thresh_rd", last_dat, 32'h4);

        // Pointer wrap
        access(2'd0, 1, 32'h1, 4'hF);
        for (int i = 0; i < 40; i++) begin
            access(2'd2, 1, $urandom, 4'hF);
            access(2'd2, 0, 0, 4'hF);
        end

        // Clear together with enable
        for (int i = 0; i < 5; i++) access(2'd2, 1, 32'hC0 + 32'(i), 4'hF);
        access(2'd0, 1, 32'h5, 4'hF);
        access(2'd1, 0, 0, 4'hF);
        chk("status_clear", last_dat, 32'h0001_0000);
        access(2'd0, 0, 0, 4'hF);
        chk("ctrl_after_clear", last_dat, 32'h1);

        // Reset during the response cycle
        @(negedge clk);
        bus.wb_adr_i = 32'h4; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk);
        #1 chk("pre_rst_ack", 32'(bus.wb_ack_o), 32'h1);
        rst_n = 1'b0;
        #1 chk("rst_ack_drop", 32'(bus.wb_ack_o), 32'h0);
        model_reset();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        access(2'd1, 0, 0, 4'hF);
        chk("status_after_rst", last_dat, 32'h0001_0000);

        // Random traffic, biased toward DATA so the FIFO visits full and empty
        for (int i = 0; i < 400; i++) begin
            int          k;
            logic [1:0]  r;
            logic [31:0] wd;
            logic [3:0]  sel;
            k   = int'($urandom_range(0, 9));
            r   = (k < 6) ? 2'd2 : 2'(k - 6);
            wd  = $urandom;
            if (r == 2'd0) wd = (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0) | 32'($urandom_range(0, 3));
            if (r == 2'd3) wd = 32'($urandom_range(0, 20));
            sel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            access(r, bit'($urandom_range(0, 1)), wd, sel);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
